// File: rtl/rom_uart_dumper.sv
// rom_uart_dumper: reads WORDS ROM words and streams them little-endian over 8N1 UART
module rom_uart_dumper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int WORDS        = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] im_ra,
  input  logic [31:0] im_rd,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] LAST = 32'(WORDS - 1);
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP, S_FIN} state_t;
  state_t        state_q, state_d;
  logic [31:0]   ra_q, ra_d, sr_q, sr_d;
  logic [1:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d, nb;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          tx_q, tx_d, tick;
  // state and datapath registers; uart_tx idles high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      sr_q    <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      sr_q    <= sr_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      tx_q    <= tx_d;
    end
  end
  // next state; tx_d is computed for the state being entered so the line is a pure flop output
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    sr_d    = sr_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    tmr_d   = tmr_q;
    tx_d    = tx_q;
    tick    = (tmr_q == '0);
    nb      = bit_q + 3'd1;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start) begin
          ra_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        sr_d    = im_rd;
        byte_d  = '0;
        tmr_d   = RELOAD;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        tmr_d = tick ? RELOAD : tmr_q - TW'(1);
        if (tick) begin
          bit_d   = '0;
          tx_d    = sr_q[{byte_q, 3'd0}];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tmr_d = tick ? RELOAD : tmr_q - TW'(1);
        if (tick) begin
          bit_d   = nb;
          tx_d    = (bit_q == 3'd7) ? 1'b1 : sr_q[{byte_q, nb}];
          state_d = (bit_q == 3'd7) ? S_STOP : S_DATA;
        end
      end
      S_STOP: begin
        tmr_d = tick ? RELOAD : tmr_q - TW'(1);
        if (tick) begin
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            tx_d    = 1'b0;
            state_d = S_START;
          end else if (ra_q != LAST) begin
            ra_d    = ra_q + 32'd1;
            state_d = S_WAIT;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  assign im_ra   = ra_q;
  assign uart_tx = tx_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done    = (state_q == S_FIN);
endmodule

// File: tb/tb_rom_uart_dumper.sv
// tb_rom_uart_dumper: random-ROM dumps on three configurations checked cycle by cycle against a waveform model
module tb_rom_uart_dumper;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;
  logic [31:0] ra_a, ra_b, ra_c, rd_a, rd_b, rd_c;
  logic        tx_a, tx_b, tx_c, by_a, by_b, by_c, dn_a, dn_b, dn_c;
  logic [31:0] rom [4];
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  // A: 4 clk/bit, 2 words, combinational ROM
  rom_uart_dumper #(.CLKS_PER_BIT(4), .WORDS(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .im_ra(ra_a), .im_rd(rd_a),
    .uart_tx(tx_a), .busy(by_a), .done(dn_a));
  // B: 2 clk/bit, 3 words, ROM with one-cycle registered read
  rom_uart_dumper #(.CLKS_PER_BIT(2), .WORDS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .im_ra(ra_b), .im_rd(rd_b),
    .uart_tx(tx_b), .busy(by_b), .done(dn_b));
  // C: 4 clk/bit, single word, combinational ROM
  rom_uart_dumper #(.CLKS_PER_BIT(4), .WORDS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(st_c), .im_ra(ra_c), .im_rd(rd_c),
    .uart_tx(tx_c), .busy(by_c), .done(dn_c));

  assign rd_a = rom[ra_a[1:0]];
  assign rd_c = rom[ra_c[1:0]];
  always @(posedge clk) rd_b <= rom[ra_b[1:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line/flags at cycle t after the start cycle (t=0), from frame arithmetic alone.
  function automatic void model(input int t, input int c, input int w,
                                output bit tx, output bit bsy, output bit dn, output int ra);
    int p, end_t, wi, r, q, by, b;
    p = 40 * c + 2;
    end_t = 1 + w * p;
    tx = 1'b1; bsy = 1'b0; dn = 1'b0; ra = w - 1;
    if (t >= 1 && t < end_t) begin
      bsy = 1'b1;
      wi = (t - 1) / p;
      r = (t - 1) % p;
      ra = wi;
      if (r >= 2) begin
        q = r - 2;
        by = q / (10 * c);
        b = (q % (10 * c)) / c;
        tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : rom[wi][8 * by + b - 1];
      end
    end
    dn = (t == end_t);
  endfunction

  task automatic get(input int id, output logic tx, output logic bsy, output logic dn, output logic [31:0] ra);
    tx  = (id == 0) ? tx_a : (id == 1) ? tx_b : tx_c;
    bsy = (id == 0) ? by_a : (id == 1) ? by_b : by_c;
    dn  = (id == 0) ? dn_a : (id == 1) ? dn_b : dn_c;
    ra  = (id == 0) ? ra_a : (id == 1) ? ra_b : ra_c;
  endtask

  // One dump on instance id; noisy adds stray starts mid-dump and in the done cycle,
  // abort_at >= 0 pulls reset at that cycle and ends the dump there.
  task automatic dump(input int id, input int c, input int w, input bit noisy, input int abort_at);
    int end_t, era;
    bit etx, ebsy, edn, s;
    logic gtx, gbsy, gdn;
    logic [31:0] gra;
    end_t = 1 + w * (40 * c + 2);
    for (int t = 0; t <= end_t + 3; t++) begin
      @(negedge clk);
      if (t == abort_at) begin
        rst_n = 1'b0;
        #1;
        get(id, gtx, gbsy, gdn, gra);
        chk("rst_tx", {31'd0, gtx}, 32'd1);
        chk("rst_busy", {31'd0, gbsy}, 32'd0);
        chk("rst_ra", gra, 32'd0);
        @(negedge clk);
        get(id, gtx, gbsy, gdn, gra);
        chk("rst_done", {31'd0, gdn}, 32'd0);
        chk("rst_tx_hold", {31'd0, gtx}, 32'd1);
        rst_n = 1'b1;
        return;
      end
      model(t, c, w, etx, ebsy, edn, era);
      get(id, gtx, gbsy, gdn, gra);
      chk("tx", {31'd0, gtx}, {31'd0, etx});
      chk("busy", {31'd0, gbsy}, {31'd0, ebsy});
      chk("done", {31'd0, gdn}, {31'd0, edn});
      if (t >= 1) chk("im_ra", gra, 32'(era));
      s = (t == 0) || (noisy && (t == 10 || t == 200 || t == end_t));
      st_a = (id == 0) && s;
      st_b = (id == 1) && s;
      st_c = (id == 2) && s;
    end
    st_a = 1'b0; st_b = 1'b0; st_c = 1'b0;
  endtask

  task automatic rnd_rom();
    for (int i = 0; i < 4; i++) rom[i] = $urandom;
  endtask

  initial begin
    rom[0] = 32'h1234_5678; rom[1] = 32'hA5C3_0F01; rom[2] = 32'hDEAD_BEEF; rom[3] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_tx_a", {31'd0, tx_a}, 32'd1);
    chk("reset_busy_a", {31'd0, by_a}, 32'd0);
    chk("reset_done_a", {31'd0, dn_a}, 32'd0);
    chk("reset_ra_a", ra_a, 32'd0);
    chk("reset_tx_b", {31'd0, tx_b}, 32'd1);
    chk("reset_ra_b", ra_b, 32'd0);
    chk("reset_tx_c", {31'd0, tx_c}, 32'd1);
    chk("reset_ra_c", ra_c, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    dump(0, 4, 2, 1'b0, -1);
    dump(0, 4, 2, 1'b1, -1);
    dump(0, 4, 2, 1'b0, 95);
    repeat (2) @(negedge clk);
    rnd_rom();
    dump(0, 4, 2, 1'b0, -1);
    rom[0] = 32'hFFFF_FFFF;
    dump(2, 4, 1, 1'b1, -1);
    rom[0] = 32'h1234_5678; rom[1] = 32'hA5C3_0F01;
    dump(1, 2, 3, 1'b1, -1);
    for (int k = 0; k < 3; k++) begin
      rnd_rom();
      dump(k % 3, (k % 3 == 1) ? 2 : 4, (k % 3 == 0) ? 2 : (k % 3 == 1) ? 3 : 1, k[0], -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
